iq_issue_ctrl: RTL

//  In-order dual-issue select/scheduler for the 16-entry issue queue.
//  - Each cycle, examines the two oldest queue entries (slot0 = oldest) and checks operand readiness

---
 rtl/iq_issue_ctrl.sv | 100 ++++++++++
 1 files changed

// File: rtl/iq_issue_ctrl.sv
// In-order dual-issue select for the issue queue head: operand readiness via a per-register
// countdown scoreboard, pipe availability, intra-pair hazards, and a flush drain state.
//
//  state | meaning
//  RUN   | normal issue from the queue head
//  DRAIN | flush seen; issue held until every scoreboard counter reaches zero
module iq_issue_ctrl #(
    parameter int NUM_REGS = 32,
    parameter int REG_W    = 5,
    parameter int MUL_LAT  = 3,
    parameter int ALU_LAT  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            iq_size,
    input  logic [1:0][REG_W-1:0] head_src1,
    input  logic [1:0][REG_W-1:0] head_src2,
    input  logic [1:0][REG_W-1:0] head_dst,
    input  logic [1:0]            head_wen,
    input  logic [1:0]            head_is_mul,
    input  logic [1:0]            pipe_ready,
    input  logic                  flush,
    output logic [1:0]            out_data_number,
    output logic [1:0]            issue_valid,
    output logic [NUM_REGS-1:0]   busy_vec,
    output logic [15:0]           stall_cycles,
    output logic                  draining
);

    localparam logic [0:0] RUN   = 1'b0;
    localparam logic [0:0] DRAIN = 1'b1;

    logic [0:0] state;
    logic [2:0] cnt [NUM_REGS];
    logic       iss0, iss1;
    logic       raw_hz, waw_hz;

    always_comb begin
        busy_vec = '0;
        for (int r = 1; r < NUM_REGS; r++) begin
            busy_vec[r] = (cnt[r] != 3'd0);
        end
    end

    always_comb begin
        raw_hz = head_wen[0] && (head_dst[0] != '0) &&
                 ((head_src1[1] == head_dst[0]) || (head_src2[1] == head_dst[0]));
        waw_hz = head_wen[0] && head_wen[1] && (head_dst[1] == head_dst[0]);
        iss0   = !rst && (state == RUN) && !flush && (iq_size != 2'd0) && pipe_ready[0] &&
                 !busy_vec[head_src1[0]] && !busy_vec[head_src2[0]];
        // Slot1 only rides along with slot0, and only when it is actually present.
        iss1   = iss0 && (iq_size == 2'd2) && pipe_ready[1] &&
                 !busy_vec[head_src1[1]] && !busy_vec[head_src2[1]] &&
                 !raw_hz && !waw_hz && !(head_is_mul[0] && head_is_mul[1]);
    end

    assign issue_valid     = {iss1, iss0};
    assign out_data_number = {1'b0, iss0} + {1'b0, iss1};
    assign draining        = (state == DRAIN);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt[r] <= 3'd0;
            end
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (r != 0 && iss0 && head_wen[0] && head_dst[0] == REG_W'(r)) begin
                    cnt[r] <= head_is_mul[0] ? 3'(MUL_LAT) : 3'(ALU_LAT);
                end else if (r != 0 && iss1 && head_wen[1] && head_dst[1] == REG_W'(r)) begin
                    cnt[r] <= head_is_mul[1] ? 3'(MUL_LAT) : 3'(ALU_LAT);
                end else if (cnt[r] != 3'd0) begin
                    cnt[r] <= cnt[r] - 3'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
        end else begin
            case (state)
                RUN:     if (flush) state <= DRAIN;
                DRAIN:   if (!flush && busy_vec == '0) state <= RUN;
                default: state <= RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= 16'd0;
        end else if (state == RUN && iq_size != 2'd0 && out_data_number == 2'd0 &&
                     stall_cycles != 16'hFFFF) begin
            stall_cycles <= stall_cycles + 16'd1;
        end
    end

endmodule
